rx_ctrl_phy: RTL and testbench

Serial control-link receiver for the byte framing produced by the existing control-link transmitter.
- Frame format: one start bit (0), eight data bits MSB first, two stop bits (1), at a runtime bit period.
- Synchronizes the asynchronous `rx_ctrl` line and detects the start bit. Samples each bit at mid-period, then delivers the byte with a one-cycle valid pulse or flags a framing error.
- Sits between the external control pin and the command decoder.

---
 rtl/ctrl_phy_pkg.sv | 39 +++
 rtl/rx_sync_edge.sv | 38 +++
 rtl/rx_ctrl_phy.sv | 127 ++++++++++++
 tb/tb_rx_ctrl_phy.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_phy_pkg.sv
// Shared definitions for the control-link PHY (transmitter and receiver).
package ctrl_phy_pkg;

   localparam int TBIT_W = 20;

   typedef enum logic [3:0] {
      S_IDLE  = 4'h0,
      S_START = 4'h1,
      S_S7    = 4'h2,
      S_S6    = 4'h3,
      S_S5    = 4'h4,
      S_S4    = 4'h5,
      S_S3    = 4'h6,
      S_S2    = 4'h7,
      S_S1    = 4'h8,
      S_S0    = 4'h9,
      S_STOP  = 4'ha,
      S_STOP2 = 4'hb,
      S_DONE  = 4'hf
   } state_t;

   // Successor of a bit-sampling state once its sample point is reached.
   function automatic state_t next_bit_state(input state_t s);
      case (s)
         S_S7:    return S_S6;
         S_S6:    return S_S5;
         S_S5:    return S_S4;
         S_S4:    return S_S3;
         S_S3:    return S_S2;
         S_S2:    return S_S1;
         S_S1:    return S_S0;
         S_S0:    return S_STOP;
         S_STOP:  return S_STOP2;
         S_STOP2: return S_DONE;
         default: return S_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/rx_sync_edge.sv
// Multi-flop synchronizer for the serial line plus falling-edge detect.
// All flops reset to 0 so a line held low out of reset never looks like a start.
module rx_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_sys,
   input  logic rst_n,
   input  logic rx_ctrl,
   output logic rx_s,
   output logic fall_s
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   // Shift the raw line through the synchronizer chain.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], rx_ctrl};
      end
   end

   assign rx_s = sync_q[SYNC_STAGES-1];

   // Remember the previous synchronized value for edge detection.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         prev_q <= 1'b0;
      end else begin
         prev_q <= rx_s;
      end
   end

   assign fall_s = prev_q & ~rx_s;

endmodule

// File: rtl/rx_ctrl_phy.sv
// Control-link byte receiver: start detect, mid-bit sampling, framing check.
//
//   state   | meaning
//   S_IDLE  | line idle, waiting for a start edge
//   S_START | waiting half a bit to confirm the start bit
//   S_S7..0 | sampling data bits, MSB first
//   S_STOP  | sampling stop bit 1
//   S_STOP2 | sampling stop bit 2
//   S_DONE  | one cycle: publish byte or flag framing error
module rx_ctrl_phy
   import ctrl_phy_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk_sys,
   input  logic              rst_n,
   input  logic              rx_ctrl,
   input  logic [TBIT_W-1:0] tbit_period,
   output logic [7:0]        data_rx,
   output logic              valid_rx,
   output logic              err_frame,
   output logic              busy_rx
);

   localparam logic [TBIT_W-1:0] ONE = {{(TBIT_W-1){1'b0}}, 1'b1};

   logic              rx_s;
   logic              fall_s;
   state_t            state_q;
   state_t            state_d;
   logic [TBIT_W-1:0] cnt_q;
   logic [TBIT_W-1:0] per_q;
   logic [TBIT_W-1:0] half_q;
   logic [7:0]        shreg_q;
   logic              stop_ok_q;
   logic              tc;
   logic              is_data;
   logic              is_stop;

   rx_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk_sys (clk_sys),
      .rst_n   (rst_n),
      .rx_ctrl (rx_ctrl),
      .rx_s    (rx_s),
      .fall_s  (fall_s)
   );

   assign half_q  = per_q >> 1;
   assign is_data = (state_q >= S_S7) && (state_q <= S_S0);
   assign is_stop = (state_q == S_STOP) || (state_q == S_STOP2);
   assign busy_rx = (state_q != S_IDLE);

   // State register.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and sample-point strobe.
   always_comb begin
      state_d = state_q;
      tc      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (fall_s) state_d = S_START;
         end
         S_START: begin
            tc = (cnt_q == half_q - ONE);
            if (tc) state_d = rx_s ? S_IDLE : S_S7;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            tc = (cnt_q == per_q - ONE);
            if (tc) state_d = next_bit_state(state_q);
         end
      endcase
   end

   // Bit counter, period latch, shift register and framing result.
   // The pulses are registered out of S_DONE so data_rx changes in the
   // same cycle valid_rx is seen.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         per_q     <= '0;
         shreg_q   <= 8'h00;
         stop_ok_q <= 1'b1;
         data_rx   <= 8'h00;
         valid_rx  <= 1'b0;
         err_frame <= 1'b0;
      end else begin
         valid_rx  <= 1'b0;
         err_frame <= 1'b0;
         case (state_q)
            S_IDLE: begin
               cnt_q <= '0;
               if (fall_s) begin
                  per_q     <= tbit_period;
                  stop_ok_q <= 1'b1;
               end
            end
            S_DONE: begin
               cnt_q <= '0;
               if (stop_ok_q) begin
                  valid_rx <= 1'b1;
                  data_rx  <= shreg_q;
               end else begin
                  err_frame <= 1'b1;
               end
            end
            default: begin
               cnt_q <= tc ? '0 : cnt_q + ONE;
               if (tc && is_data) shreg_q <= {shreg_q[6:0], rx_s};
               if (tc && is_stop) stop_ok_q <= stop_ok_q & rx_s;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rx_ctrl_phy.sv
// Bench for rx_ctrl_phy: a bit-level transmitter feeds frames, a scoreboard
// queue holds the expected pulse for each full frame, and a monitor checks
// each pulse for kind, byte and latency.
module tb_rx_ctrl_phy;

   localparam int SYNC = 2;

   logic        clk_sys = 1'b0;
   logic        rst_n = 1'b0;
   logic        rx_ctrl = 1'b1;
   logic [19:0] tbit_period = 20'd16;
   logic [7:0]  data_rx;
   logic        valid_rx;
   logic        err_frame;
   logic        busy_rx;

   rx_ctrl_phy #(.SYNC_STAGES(SYNC)) dut (
      .clk_sys     (clk_sys),
      .rst_n       (rst_n),
      .rx_ctrl     (rx_ctrl),
      .tbit_period (tbit_period),
      .data_rx     (data_rx),
      .valid_rx    (valid_rx),
      .err_frame   (err_frame),
      .busy_rx     (busy_rx)
   );

   always #5 clk_sys = ~clk_sys;

   longint cyc = 0;
   always @(posedge clk_sys) cyc <= cyc + 1;

   int vectors = 0;
   int miscompares = 0;
   int pulses = 0;
   int exp_pulses = 0;

   typedef struct {
      bit         is_err;
      logic [7:0] data;
      longint     t0;
      int         per;
   } exp_t;

   exp_t       exp_q[$];
   exp_t       mon_e;
   longint     valid_times[$];
   logic [7:0] model_last = 8'h00;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_rng(input string name, input longint act, input longint lo, input longint hi);
      vectors++;
      if (act < lo || act > hi) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   // Line fall to pulse, from the documented latency formula.
   function automatic longint lat(input int p);
      return longint'(SYNC + 1 + (p >> 1) + 10 * p + 1);
   endfunction

   // Transmit up to nbits of a frame (start, 8 data MSB first, 2 stops).
   // Called and returns at a negedge. Only full frames are scoreboarded.
   task automatic send_frame(input logic [7:0] b, input int per, input bit bad2, input int nbits);
      logic [10:0] bits;
      exp_t        e;
      bits = {1'b0, b, 1'b1, ~bad2};
      if (nbits == 11) begin
         e.is_err = bad2;
         e.data   = bad2 ? model_last : b;
         e.t0     = cyc;
         e.per    = per;
         exp_q.push_back(e);
         exp_pulses++;
         if (!bad2) model_last = b;
      end
      for (int i = 10; i > 10 - nbits; i--) begin
         rx_ctrl = bits[i];
         repeat (per) @(negedge clk_sys);
      end
      rx_ctrl = 1'b1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 15000) begin
         @(negedge clk_sys);
         n++;
      end
      check("drain_timeout", exp_q.size(), 0);
      repeat (8) @(negedge clk_sys);
   endtask

   // Monitor: every pulse is matched against the head of the scoreboard.
   always @(negedge clk_sys) begin
      if (rst_n && (valid_rx || err_frame)) begin
         pulses++;
         if (valid_rx) valid_times.push_back(cyc);
         check("pulse_exclusive", valid_rx & err_frame, 0);
         check("pulse_expected", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("err_frame", err_frame, mon_e.is_err);
            check("valid_rx", valid_rx, !mon_e.is_err);
            check("data_rx", data_rx, mon_e.data);
            check_rng("latency", cyc - mon_e.t0, lat(mon_e.per) - 1, lat(mon_e.per) + 1);
         end
      end
   end

   initial begin
      #(10 * 100000);
      $display("FAIL watchdog: simulation did not complete");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      int per;
      logic [7:0] b;
      bit bad;

      repeat (3) @(negedge clk_sys);
      check("rst_data_rx", data_rx, 8'h00);
      check("rst_valid_rx", valid_rx, 0);
      check("rst_err_frame", err_frame, 0);
      check("rst_busy_rx", busy_rx, 0);
      rst_n = 1'b1;
      repeat (10) @(negedge clk_sys);
      check("idle_busy_after_release", busy_rx, 0);

      // Single clean frame.
      tbit_period = 20'd16;
      send_frame(8'hA5, 16, 1'b0, 11);
      drain();

      // Back-to-back frames at the same period.
      valid_times.delete();
      send_frame(8'h3C, 16, 1'b0, 11);
      send_frame(8'hC3, 16, 1'b0, 11);
      drain();
      check("b2b_valid_count", valid_times.size(), 2);
      if (valid_times.size() == 2)
         check("b2b_spacing", valid_times[1] - valid_times[0], 176);

      // Short glitch on the line.
      p0 = pulses;
      rx_ctrl = 1'b0;
      repeat (3) @(negedge clk_sys);
      rx_ctrl = 1'b1;
      repeat (3) @(negedge clk_sys);
      check("glitch_busy_high", busy_rx, 1);
      repeat (15) @(negedge clk_sys);
      check("glitch_busy_low", busy_rx, 0);
      check("glitch_no_pulse", pulses, p0);

      // Stop bit 2 low.
      send_frame(8'h5A, 16, 1'b1, 11);
      drain();
      check("err_keeps_data", data_rx, 8'hC3);

      // Reset asserted while the receiver is in S3.
      p0 = pulses;
      send_frame(8'h99, 16, 1'b0, 5);
      rx_ctrl = 1'b1;
      repeat (4) @(negedge clk_sys);
      rst_n = 1'b0;
      repeat (4) @(negedge clk_sys);
      check("midrst_data_rx", data_rx, 8'h00);
      check("midrst_busy_rx", busy_rx, 0);
      model_last = 8'h00;
      rst_n = 1'b1;
      repeat (40) @(negedge clk_sys);
      check("midrst_no_pulse", pulses, p0);
      send_frame(8'h81, 16, 1'b0, 11);
      drain();

      // Period extremes, changed between frames.
      tbit_period = 20'd4;
      send_frame(8'hFF, 4, 1'b0, 11);
      drain();
      tbit_period = 20'd1000;
      send_frame(8'h00, 1000, 1'b0, 11);
      drain();

      // Period changed mid-frame: latched period still applies.
      tbit_period = 20'd16;
      fork
         send_frame(8'h6B, 16, 1'b0, 11);
         begin
            repeat (60) @(negedge clk_sys);
            tbit_period = 20'd9;
         end
      join
      drain();

      // Randomized frames.
      for (int k = 0; k < 12; k++) begin
         per = int'($urandom_range(4, 40));
         b   = 8'($urandom_range(0, 255));
         bad = ($urandom_range(0, 4) == 0);
         tbit_period = 20'(per);
         send_frame(b, per, bad, 11);
         drain();
         repeat ($urandom_range(0, 5)) @(negedge clk_sys);
      end

      check("total_pulses", pulses, exp_pulses);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
